// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target holding a small byte-wide register file.
// It answers bus address SLAVE_ADDR. The first byte after the address
// selects a register pointer. Further written bytes are stored at the
// pointer, which auto-increments. Reads return reg[ptr] and
// auto-increment. SCL/SDA are oversampled on ACLK; SCL is never stretched.
//
// Ports:
//   ACLK       system clock, all logic on rising edge
//   ARESETN    asynchronous active-low reset
//   scl_i      SCL pin level (asynchronous)
//   sda_i      SDA pin level (asynchronous)
//   sda_oe     1 = pull SDA low (open-drain), 0 = release
//   reg_out    register file contents, reg k at [8k+7:8k]
//   wr_strobe  one-cycle pulse when a data byte is written
//   wr_index   register index belonging to wr_strobe
//   busy       high while this target is addressed
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              scl_i,
    input  logic                              sda_i,
    output logic                              sda_oe,
    output logic [NUM_REGS*8-1:0]             reg_out,
    output logic                              wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0]       wr_index,
    output logic                              busy
);

    localparam int                IDX_W      = $clog2(NUM_REGS);
    localparam logic [7:0]        NUM_REGS_B = 8'(NUM_REGS);
    localparam logic [IDX_W-1:0]  PTR_ONE    = IDX_W'(1'b1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } state_t;

    // Synchronizer chains: meta -> sync, plus a history flop for edges.
    logic scl_meta_r, scl_sync_r, scl_hist_r;
    logic sda_meta_r, sda_sync_r, sda_hist_r;

    state_t           state_r;
    logic [3:0]       bit_cnt_r;
    logic [6:0]       rx_shift_r;
    logic [7:0]       tx_shift_r;
    logic [IDX_W-1:0] ptr_r;
    logic             rw_r;
    // ACK states: 0 = waiting for the fall that starts the ACK/next byte
    // phase, 1 = ACK phase in progress (or master ACK seen in RDATA_ACK).
    logic             ack_phase_r;

    logic       scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0] rx_byte_s;
    logic [7:0] rd_byte_s;

    // Edge and bus-condition detection use synchronized values only.
    assign scl_rise_s = scl_sync_r & ~scl_hist_r;
    assign scl_fall_s = ~scl_sync_r & scl_hist_r;
    assign start_s    = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;

    // Byte as it stands once the current bit is shifted in.
    assign rx_byte_s  = {rx_shift_r, sda_sync_r};
    // Register currently addressed by the pointer (read path).
    assign rd_byte_s  = reg_out[{ptr_r, 3'b000} +: 8];

    // Two-flop synchronizers plus history; reset to the idle bus level so
    // reset release cannot fabricate a START.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_hist_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_hist_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_i;
            scl_sync_r <= scl_meta_r;
            scl_hist_r <= scl_sync_r;
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
            sda_hist_r <= sda_sync_r;
        end
    end

    // Protocol FSM with registered outputs and the register file.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 4'd0;
            rx_shift_r  <= 7'd0;
            tx_shift_r  <= 8'd0;
            ptr_r       <= '0;
            rw_r        <= 1'b0;
            ack_phase_r <= 1'b0;
            sda_oe      <= 1'b0;
            reg_out     <= '0;
            wr_strobe   <= 1'b0;
            wr_index    <= '0;
            busy        <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_s) begin
                // START or repeated START: abort any byte, keep the pointer.
                state_r     <= ADDR;
                bit_cnt_r   <= 4'd0;
                ack_phase_r <= 1'b0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
            end else if (stop_s) begin
                state_r     <= IDLE;
                bit_cnt_r   <= 4'd0;
                ack_phase_r <= 1'b0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end

                    ADDR: begin
                        if (scl_rise_s) begin
                            rx_shift_r <= rx_byte_s[6:0];
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r <= 4'd0;
                                if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                                    rw_r    <= rx_byte_s[0];
                                    state_r <= ADDR_ACK;
                                    busy    <= 1'b1;
                                end else begin
                                    state_r <= IGNORE;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end

                    PTR: begin
                        if (scl_rise_s) begin
                            rx_shift_r <= rx_byte_s[6:0];
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r <= 4'd0;
                                if (rx_byte_s < NUM_REGS_B) begin
                                    ptr_r   <= rx_byte_s[IDX_W-1:0];
                                    state_r <= PTR_ACK;
                                end else begin
                                    state_r <= IGNORE;
                                    busy    <= 1'b0;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end

                    WDATA: begin
                        if (scl_rise_s) begin
                            rx_shift_r <= rx_byte_s[6:0];
                            if (bit_cnt_r == 4'd7) begin
                                // Byte complete: commit only now so an aborted
                                // byte never touches the register file.
                                bit_cnt_r                   <= 4'd0;
                                reg_out[{ptr_r, 3'b000} +: 8] <= rx_byte_s;
                                wr_strobe                   <= 1'b1;
                                wr_index                    <= ptr_r;
                                ptr_r                       <= ptr_r + PTR_ONE;
                                state_r                     <= WDATA_ACK;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end

                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_phase_r) begin
                                sda_oe      <= 1'b1;
                                ack_phase_r <= 1'b1;
                            end else begin
                                ack_phase_r <= 1'b0;
                                bit_cnt_r   <= 4'd0;
                                if (state_r == ADDR_ACK && rw_r) begin
                                    // Read: first data bit goes out on this fall.
                                    tx_shift_r <= rd_byte_s;
                                    sda_oe     <= ~rd_byte_s[7];
                                    state_r    <= RDATA;
                                end else if (state_r == ADDR_ACK) begin
                                    sda_oe  <= 1'b0;
                                    state_r <= PTR;
                                end else begin
                                    sda_oe  <= 1'b0;
                                    state_r <= WDATA;
                                end
                            end
                        end
                    end

                    RDATA: begin
                        if (scl_rise_s) begin
                            bit_cnt_r  <= bit_cnt_r + 4'd1;
                            tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                        end else if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd8) begin
                                sda_oe      <= 1'b0;
                                ptr_r       <= ptr_r + PTR_ONE;
                                bit_cnt_r   <= 4'd0;
                                ack_phase_r <= 1'b0;
                                state_r     <= RDATA_ACK;
                            end else begin
                                sda_oe <= ~tx_shift_r[7];
                            end
                        end
                    end

                    RDATA_ACK: begin
                        if (scl_rise_s) begin
                            if (!sda_sync_r) begin
                                ack_phase_r <= 1'b1;
                            end else begin
                                state_r <= IGNORE;
                                busy    <= 1'b0;
                                sda_oe  <= 1'b0;
                            end
                        end else if (scl_fall_s && ack_phase_r) begin
                            // Master ACKed: next byte, first bit on this fall.
                            ack_phase_r <= 1'b0;
                            bit_cnt_r   <= 4'd0;
                            tx_shift_r  <= rd_byte_s;
                            sda_oe      <= ~rd_byte_s[7];
                            state_r     <= RDATA;
                        end
                    end

                    IGNORE: begin
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end

                    default: begin
                        state_r     <= IDLE;
                        sda_oe      <= 1'b0;
                        busy        <= 1'b0;
                        ack_phase_r <= 1'b0;
                        bit_cnt_r   <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
